// File: rtl/axi_burst_read_master_if.sv
// AXI4 read-address (AR) and read-data (R) channel bundle.
// master: drives AR payload/ARVALID and RREADY; samples ARREADY and the R payload.
// slave:  the mirror image (memory or interconnect side).
interface axi_burst_read_master_if #(
    parameter int unsigned C_M_AXI_ID_WIDTH     = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH   = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_M_AXI_ARUSER_WIDTH = 1,
    parameter int unsigned C_M_AXI_ARLOCK_WIDTH = 2,
    parameter int unsigned C_M_AXI_RUSER_WIDTH  = 1
) ();
    // AR channel
    logic [C_M_AXI_ID_WIDTH-1:0]     ARID;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]                      ARLEN;
    logic [2:0]                      ARSIZE;
    logic [1:0]                      ARBURST;
    logic [C_M_AXI_ARLOCK_WIDTH-1:0] ARLOCK;
    logic [3:0]                      ARCACHE;
    logic [2:0]                      ARPROT;
    logic [3:0]                      ARQOS;
    logic [C_M_AXI_ARUSER_WIDTH-1:0] ARUSER;
    logic                            ARVALID;
    logic                            ARREADY;
    // R channel
    logic [C_M_AXI_ID_WIDTH-1:0]     RID;
    logic [C_M_AXI_DATA_WIDTH-1:0]   RDATA;
    logic [1:0]                      RRESP;
    logic                            RLAST;
    logic [C_M_AXI_RUSER_WIDTH-1:0]  RUSER;
    logic                            RVALID;
    logic                            RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER,
        output ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
        output RREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER,
        input  ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi_burst_read_master.sv
// Read-side DMA engine: splits a (start address, beat count) command into AXI4 INCR read
// bursts that never cross a 4 KB page, keeps at most MAX_OUTSTANDING bursts in flight and
// forwards returned beats combinationally as a ready/valid stream.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESET      clock, synchronous active-high reset
//   cmd_addr/cmd_beats/cmd_valid/cmd_ready   command handshake
//   out_data/out_last/out_valid/out_ready    output beat stream (out_last = final beat)
//   done (1-cycle pulse), err (sticky RRESP[1] seen), busy (not idle)
//   m_axi                          AXI4 AR/R master port
module axi_burst_read_master #(
    parameter int unsigned C_M_AXI_ID_WIDTH     = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH   = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_M_AXI_ARUSER_WIDTH = 1,
    parameter int unsigned C_M_AXI_ARLOCK_WIDTH = 2,
    parameter int unsigned BURST_LEN            = 16,
    parameter int unsigned MAX_OUTSTANDING      = 4,
    parameter int unsigned LEN_WIDTH            = 24
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]          cmd_beats,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] out_data,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          done,
    output logic                          err,
    output logic                          busy,
    axi_burst_read_master_if.master       m_axi
);
    localparam int unsigned BytesPerBeat = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned SizeLog2     = $clog2(BytesPerBeat);
    localparam int unsigned OutW         = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] AlignMask =
        C_M_AXI_ADDR_WIDTH'((1 << SizeLog2) - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StIssue, StDrain} state_e;

    state_e                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]            remaining_q, remaining_d;
    logic [8:0]                      len_q, len_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]                      arlen_q, arlen_d;
    logic [OutW-1:0]                 outstanding_q, outstanding_d;
    logic                            err_q, err_d;
    logic                            done_q, done_d;

    logic        ar_hs;
    logic        r_hs;
    logic        r_last_hs;
    logic [12:0] page_beats;
    logic [31:0] burst_cap;
    logic [8:0]  len_calc;

    assign ar_hs     = m_axi.ARVALID & m_axi.ARREADY;
    assign r_hs      = m_axi.RVALID & m_axi.RREADY;
    assign r_last_hs = r_hs & m_axi.RLAST;

    // Burst length: limited by BURST_LEN, beats still to request, and beats left in the page.
    always_comb begin
        page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> SizeLog2;
        burst_cap  = 32'(page_beats);
        if (burst_cap > BURST_LEN) begin
            burst_cap = BURST_LEN;
        end
        if (32'(remaining_q) < burst_cap) begin
            burst_cap = 32'(remaining_q);
        end
        len_calc = 9'(burst_cap);
    end

    // AR channel: fixed attributes, registered address/length.
    assign m_axi.ARID    = '0;
    assign m_axi.ARADDR  = araddr_q;
    assign m_axi.ARLEN   = arlen_q;
    assign m_axi.ARSIZE  = 3'(SizeLog2);
    assign m_axi.ARBURST = 2'b01;
    assign m_axi.ARLOCK  = '0;
    assign m_axi.ARCACHE = 4'b0011;
    assign m_axi.ARPROT  = 3'b000;
    assign m_axi.ARQOS   = 4'b0000;
    assign m_axi.ARUSER  = '0;
    // outstanding cannot rise while in StIssue without a handshake, so once this goes high it
    // stays high until ARREADY.
    assign m_axi.ARVALID = (state_q == StIssue) && (outstanding_q < OutW'(MAX_OUTSTANDING));

    // R channel passes straight through; gated off when idle so stale beats are dropped.
    assign busy         = (state_q != StIdle);
    assign out_data     = m_axi.RDATA;
    assign out_valid    = m_axi.RVALID & busy;
    assign m_axi.RREADY = out_ready & busy;
    assign out_last     = m_axi.RLAST & (state_q == StDrain) & (outstanding_q == OutW'(1));

    assign cmd_ready = (state_q == StIdle) & ~M_AXI_ARESET;
    assign done      = done_q;
    assign err       = err_q;

    logic unused_r;
    assign unused_r = ^{m_axi.RID, m_axi.RUSER, m_axi.RRESP[0]};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        len_d       = len_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        err_d       = err_q;
        done_d      = 1'b0;

        if (r_hs && m_axi.RRESP[1]) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d      = cmd_addr & ~AlignMask;
                        remaining_d = cmd_beats;
                        err_d       = 1'b0;
                        state_d     = StCalc;
                    end
                end
            end
            StCalc: begin
                len_d    = len_calc;
                araddr_d = addr_q;
                arlen_d  = 8'(len_calc - 9'd1);
                state_d  = StIssue;
            end
            StIssue: begin
                if (ar_hs) begin
                    addr_d      = addr_q + (C_M_AXI_ADDR_WIDTH'(len_q) << SizeLog2);
                    remaining_d = remaining_q - LEN_WIDTH'(len_q);
                    state_d     = (remaining_q == LEN_WIDTH'(len_q)) ? StDrain : StCalc;
                end
            end
            StDrain: begin
                if (r_hs && out_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (ar_hs && !r_last_hs) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (!ar_hs && r_last_hs) begin
            outstanding_d = outstanding_q - OutW'(1);
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            remaining_q   <= '0;
            len_q         <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            len_q         <= len_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            done_q        <= done_d;
        end
    end
endmodule

// File: tb/tb_axi_burst_read_master.sv
// Bench for axi_burst_read_master: a table of commands with hand-computed AR sequences, plus
// directed sequences for zero-length commands, the outstanding limit and mid-command reset.
module tb_axi_burst_read_master;
    localparam logic [31:0] DataBase = 32'hD000_0000;

    typedef struct {
        logic [31:0]      addr;
        int               beats;
        int               n_ar;
        logic [2:0][31:0] ar_a;
        logic [2:0][7:0]  ar_l;
        bit               toggle;
        int               err_burst;
        bit               exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_addr;
    logic [23:0] cmd_beats;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        err;
    logic        busy;

    axi_burst_read_master_if axi ();

    axi_burst_read_master dut (
        .M_AXI_ACLK  (clk),
        .M_AXI_ARESET(rst),
        .cmd_addr    (cmd_addr),
        .cmd_beats   (cmd_beats),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .m_axi       (axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    // Slave controls
    bit ar_ready_en = 1'b1;
    bit r_hold = 1'b0;
    bit toggle_mode = 1'b0;
    int err_burst = -1;

    // Slave model state
    int burst_len_q[$];
    int burst_idx_q[$];
    int beat_in_burst = 0;
    int data_ctr = 0;
    int ar_idx = 0;
    int model_out = 0;

    // Logs
    logic [31:0] ar_addr_log[$];
    int          ar_len_log[$];
    logic [31:0] out_data_log[$];
    bit          out_last_log[$];
    int          done_cyc_log[$];
    bit          err_at_done_log[$];
    int          last_beat_cyc = -1;
    int          first_arvalid_cyc = -1;
    int          arvalid_gap_viol = 0;
    int          full_viol = 0;
    int          rready_viol = 0;

    // Slave + monitor: drive at negedge, observe settled handshakes 1 time unit later.
    initial begin : slave
        bit ar_hs;
        bit r_hs;
        bit prev_ar_hs;
        bit exp_rready;
        prev_ar_hs  = 1'b0;
        out_ready   = 1'b1;
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RDATA   = '0;
        axi.RLAST   = 1'b0;
        axi.RRESP   = 2'b00;
        axi.RID     = '0;
        axi.RUSER   = '0;
        forever begin
            @(negedge clk);
            axi.ARREADY = ar_ready_en;
            out_ready   = toggle_mode ? ~out_ready : 1'b1;
            if (!r_hold && burst_len_q.size() > 0) begin
                axi.RVALID = 1'b1;
                axi.RDATA  = DataBase + 32'(data_ctr);
                axi.RLAST  = (beat_in_burst == burst_len_q[0]);
                axi.RRESP  = (burst_idx_q[0] == err_burst && beat_in_burst == 2) ? 2'b10 : 2'b00;
            end else begin
                axi.RVALID = 1'b0;
                axi.RLAST  = 1'b0;
                axi.RRESP  = 2'b00;
            end
            #1;
            if (!rst) begin
                ar_hs = axi.ARVALID && axi.ARREADY;
                r_hs  = axi.RVALID && axi.RREADY;
                if (axi.ARVALID && first_arvalid_cyc < 0) first_arvalid_cyc = cyc;
                if (prev_ar_hs && axi.ARVALID) arvalid_gap_viol++;
                if (axi.ARVALID && model_out >= 4) full_viol++;
                exp_rready = busy ? out_ready : 1'b0;
                if (axi.RREADY !== exp_rready) rready_viol++;
                if (out_valid && out_ready) begin
                    out_data_log.push_back(out_data);
                    out_last_log.push_back(out_last);
                    last_beat_cyc = cyc;
                end
                if (done) begin
                    done_cyc_log.push_back(cyc);
                    err_at_done_log.push_back(err);
                end
                if (ar_hs) begin
                    ar_addr_log.push_back(axi.ARADDR);
                    ar_len_log.push_back(int'(axi.ARLEN));
                    burst_len_q.push_back(int'(axi.ARLEN));
                    burst_idx_q.push_back(ar_idx);
                    ar_idx++;
                    model_out++;
                end
                if (r_hs) begin
                    data_ctr++;
                    if (axi.RLAST) begin
                        void'(burst_len_q.pop_front());
                        void'(burst_idx_q.pop_front());
                        beat_in_burst = 0;
                        model_out--;
                    end else begin
                        beat_in_burst++;
                    end
                end
                prev_ar_hs = ar_hs;
            end else begin
                prev_ar_hs    = 1'b0;
                model_out     = 0;
                beat_in_burst = 0;
                burst_len_q.delete();
                burst_idx_q.delete();
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Runs between posedge and negedge, when the monitor is idle.
    task automatic clear_logs(input bit tog, input int eb);
        @(posedge clk);
        #2;
        ar_addr_log.delete();
        ar_len_log.delete();
        out_data_log.delete();
        out_last_log.delete();
        done_cyc_log.delete();
        err_at_done_log.delete();
        last_beat_cyc     = -1;
        first_arvalid_cyc = -1;
        arvalid_gap_viol  = 0;
        full_viol         = 0;
        rready_viol       = 0;
        data_ctr          = 0;
        ar_idx            = 0;
        toggle_mode       = tog;
        err_burst         = eb;
    endtask

    task automatic send_cmd(input logic [31:0] addr, input int beats, output int acc);
        @(negedge clk);
        cmd_addr  = addr;
        cmd_beats = 24'(beats);
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cyc_log.size() == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input int beats);
        int bad_data;
        int bad_last;
        bad_data = 0;
        bad_last = 0;
        check({tag, "_beats"}, 32'(out_data_log.size()), 32'(beats));
        for (int i = 0; i < out_data_log.size(); i++) begin
            if (out_data_log[i] !== DataBase + 32'(i)) bad_data++;
            if (out_last_log[i] !== (i == beats - 1)) bad_last++;
        end
        check({tag, "_data_errs"}, 32'(bad_data), 32'd0);
        check({tag, "_last_errs"}, 32'(bad_last), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cyc_log.size()), 32'd1);
        if (done_cyc_log.size() > 0) begin
            check({tag, "_done_cyc"}, 32'(done_cyc_log[0]), 32'(last_beat_cyc + 1));
        end
        check({tag, "_rready_mirror"}, 32'(rready_viol), 32'd0);
        check({tag, "_arvalid_gap"}, 32'(arvalid_gap_viol), 32'd0);
        check({tag, "_full_limit"}, 32'(full_viol), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int acc;
        clear_logs(v.toggle, v.err_burst);
        send_cmd(v.addr, v.beats, acc);
        wait_done(600);
        check({tag, "_n_ar"}, 32'(ar_addr_log.size()), 32'(v.n_ar));
        for (int i = 0; i < v.n_ar; i++) begin
            if (i < ar_addr_log.size()) begin
                check($sformatf("%s_araddr%0d", tag, i), ar_addr_log[i], v.ar_a[i]);
                check($sformatf("%s_arlen%0d", tag, i), 32'(ar_len_log[i]), 32'(v.ar_l[i]));
            end
        end
        check({tag, "_first_arvalid"}, 32'(first_arvalid_cyc), 32'(acc + 2));
        check_stream(tag, v.beats);
        if (err_at_done_log.size() > 0) begin
            check({tag, "_err_at_done"}, 32'(err_at_done_log[0]), 32'(v.exp_err));
        end
        check({tag, "_err_after"}, 32'(err), 32'(v.exp_err));
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input int beats, input int n_ar,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [7:0] l0,
                                input logic [7:0] l1, input logic [7:0] l2, input bit tog,
                                input int eb, input bit ee);
        vec_t v;
        v.addr      = addr;
        v.beats     = beats;
        v.n_ar      = n_ar;
        v.ar_a[0]   = a0;
        v.ar_a[1]   = a1;
        v.ar_a[2]   = a2;
        v.ar_l[0]   = l0;
        v.ar_l[1]   = l1;
        v.ar_l[2]   = l2;
        v.toggle    = tog;
        v.err_burst = eb;
        v.exp_err   = ee;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin : main
        int acc;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;

        //            addr        beats n  ar0          ar1          ar2          l0  l1  l2 tog eb ee
        vecs[0] = mk(32'h1000, 16, 1, 32'h1000, 32'h0,    32'h0,    15, 0,  0, 0, -1, 0);
        vecs[1] = mk(32'h0FE0, 33, 3, 32'h0FE0, 32'h1000, 32'h1040, 7,  15, 8, 0, -1, 0);
        vecs[2] = mk(32'h0FE0, 33, 3, 32'h0FE0, 32'h1000, 32'h1040, 7,  15, 8, 0, 1,  1);
        vecs[3] = mk(32'h2000, 16, 1, 32'h2000, 32'h0,    32'h0,    15, 0,  0, 1, -1, 0);
        vecs[4] = mk(32'h0FF3, 5,  2, 32'h0FF0, 32'h1000, 32'h0,    3,  0,  0, 0, -1, 0);
        vecs[5] = mk(32'h3000, 1,  1, 32'h3000, 32'h0,    32'h0,    0,  0,  0, 0, -1, 0);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_arvalid", 32'(axi.ARVALID), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_araddr", axi.ARADDR, 32'd0);
        check("rst_arlen", 32'(axi.ARLEN), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("arsize", 32'(axi.ARSIZE), 32'd2);
        check("arburst", 32'(axi.ARBURST), 32'd1);
        check("arcache", 32'(axi.ARCACHE), 32'd3);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Zero-beat command: no AR, done one cycle after accept.
        clear_logs(1'b0, -1);
        send_cmd(32'h5000, 0, acc);
        wait_done(20);
        check("zero_n_ar", 32'(ar_addr_log.size()), 32'd0);
        check("zero_done_cnt", 32'(done_cyc_log.size()), 32'd1);
        if (done_cyc_log.size() > 0) check("zero_done_cyc", 32'(done_cyc_log[0]), 32'(acc + 1));
        check("zero_no_arvalid", 32'(first_arvalid_cyc), 32'hFFFF_FFFF);
        check("zero_busy", 32'(busy), 32'd0);

        // Outstanding limit: no R data for 40 cycles.
        clear_logs(1'b0, -1);
        r_hold = 1'b1;
        send_cmd(32'h0, 128, acc);
        repeat (40) @(negedge clk);
        #1;
        check("lim_n_ar_stalled", 32'(ar_addr_log.size()), 32'd4);
        check("lim_arvalid_low", 32'(axi.ARVALID), 32'd0);
        check("lim_busy", 32'(busy), 32'd1);
        r_hold = 1'b0;
        wait_done(1000);
        check("lim_n_ar_total", 32'(ar_addr_log.size()), 32'd8);
        if (ar_addr_log.size() == 8) check("lim_last_araddr", ar_addr_log[7], 32'h1C0);
        check_stream("lim", 128);

        // Reset while ARVALID is waiting for ARREADY.
        clear_logs(1'b0, -1);
        ar_ready_en = 1'b0;
        r_hold      = 1'b1;
        send_cmd(32'h4000, 16, acc);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (axi.ARVALID) break;
            @(negedge clk);
        end
        check("mid_arvalid_before", 32'(axi.ARVALID), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_arvalid_after", 32'(axi.ARVALID), 32'd0);
        check("mid_busy_after", 32'(busy), 32'd0);
        check("mid_n_ar", 32'(ar_addr_log.size()), 32'd0);
        ar_ready_en = 1'b1;
        r_hold      = 1'b0;
        run_vec(vecs[0], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_burst_read_master.md
# axi_burst_read_master

Read-side DMA engine that turns a (start address, beat count) command into a sequence of AXI4 INCR read bursts and streams the returned data out as a ready/valid beat stream. It sits directly upstream of the burst flow controller: its AR/R master port drives that block's slave side, whose ARREADY gating throttles it against downstream FIFO occupancy. Read-only; no AW/W/B ports.

## Interface
- C_M_AXI_ID_WIDTH, 1, ARID/RID width
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width (32/64/128)
- C_M_AXI_ARUSER_WIDTH, 1, ARUSER width
- C_M_AXI_ARLOCK_WIDTH, 2, ARLOCK width
- BURST_LEN, 16, max beats per burst (power of 2, 1..256)
- MAX_OUTSTANDING, 4, max issued-but-incomplete bursts (1..15)
- LEN_WIDTH, 24, width of command beat count
- M_AXI_ACLK  in  1  clock; the only clock
- M_AXI_ARESET  in  1  synchronous, active-high reset
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits ignored (forced 0)
- cmd_beats  in  LEN_WIDTH  total beats
- cmd_valid / cmd_ready  in / out  1  command handshake
- out_data  out  C_M_AXI_DATA_WIDTH  read beat
- out_last  out  1  final beat of command
- out_valid / out_ready  out / in  1  output handshake
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: any RRESP[1]=1 during current command
- busy  out  1  state != IDLE
- M_AXI_ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID  out; ARREADY in  AXI4 AR channel
- M_AXI_RID, RDATA, RRESP, RLAST, RUSER, RVALID  in; RREADY out  AXI4 R channel

## Operation
- Constants: ARID=0, ARSIZE=log2(DATA_WIDTH/8), ARBURST=2'b01, ARLOCK=0, ARCACHE=4'b0011, ARPROT=0, ARQOS=0, ARUSER=0.
- FSM IDLE -> CALC -> ISSUE -> (CALC | DRAIN) -> IDLE.
- IDLE: cmd_ready=1. On handshake with cmd_beats=0: done pulses next cycle, stay IDLE. Else latch addr/remaining=cmd_beats, clear err, -> CALC.
- CALC (1 cycle): len = min(BURST_LEN, remaining, (4096 - addr[11:0]) / bytes_per_beat); register ARADDR=addr, ARLEN=len-1; -> ISSUE.
- ISSUE: ARVALID=1 only when outstanding < MAX_OUTSTANDING; ARADDR/ARLEN held stable until ARREADY. On handshake: addr += len*bytes_per_beat, remaining -= len, outstanding++; remaining=0 -> DRAIN, else CALC.
- outstanding: +1 on AR handshake, −1 on R handshake with RLAST; both same cycle -> unchanged.
- R path (combinational): out_data=RDATA, out_valid=RVALID & busy, RREADY=out_ready & busy; out_last = RLAST & (state=DRAIN) & (outstanding=1).
- err |= RRESP[1] on each R handshake; data still forwarded.
- DRAIN: on R handshake with out_last=1 -> IDLE, done pulses following cycle.
- Never crosses a 4 KB boundary; never sends ARVALID while outstanding = MAX_OUTSTANDING.

## Timing
- Reset: state IDLE; ARVALID=0, cmd_ready=0 while M_AXI_ARESET=1, done=0, err=0, busy=0, outstanding=0, ARADDR=0, ARLEN=0.
- Cmd accept at cycle N -> ARVALID first high at N+2 (one CALC cycle).
- After each AR handshake ARVALID low for exactly one cycle (CALC), then re-asserted if outstanding permits.
- ARVALID, once high, never drops before ARREADY (AXI rule); outstanding limit evaluated only before assertion.
- R path zero latency; backpressure out_ready=0 stalls RREADY same cycle.
- done high exactly one cycle, cycle after final beat handshake.
- Reset mid-command: all state cleared next edge; in-flight R beats after reset are not forwarded (RREADY=0 in IDLE).

## Test plan
- cmd_addr=0x1000, cmd_beats=16, ARREADY/RVALID/out_ready always 1 -> one AR (ARADDR=0x1000, ARLEN=15, ARSIZE=2), 16 beats, out_last on beat 16, done 1 cycle later.
- cmd_addr=0x0FE0, cmd_beats=33 -> ARs (0x0FE0, ARLEN=7), (0x1000, 15), (0x1040, 8); no 4 KB crossing; 33 beats out.
- cmd_beats=128, ARREADY=1, RVALID=0 for 40 cycles -> exactly 4 ARs issued, ARVALID then held low until first RLAST accepted.
- Burst 2 of 3 returns RRESP=2'b10 on one beat -> err=1 through done; all beats forwarded; next cmd accept clears err.
- out_ready toggled 1/0 every cycle during 16-beat read -> RREADY mirrors out_ready, no beat lost or duplicated; cmd_beats=0 -> no AR, done pulse one cycle after accept.
- Assert M_AXI_ARESET during ISSUE with ARVALID high -> next cycle ARVALID=0, busy=0, outstanding=0; new command then completes normally.
